// File: rtl/mcpu_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// header size and per-state output decode.
package mcpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES = 2;

    function automatic logic state_ready(input state_t s);
        return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) || (s == S_CSUM);
    endfunction

    // The CPU stays frozen on error so it never runs a partial image.
    function automatic logic state_hold(input state_t s);
        return state_ready(s) || (s == ERR);
    endfunction

endpackage

// File: rtl/ins_mem_loader.sv
// Framed byte-stream loader: header word count, payload bytes written to
// consecutive instruction-memory addresses, trailing XOR checksum.
module ins_mem_loader
    import mcpu_loader_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    state_t             state_q, state_d;
    logic               in_ready_q, cpu_hold_q, done_q, err_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [7:0]         wr_data_q;
    logic [7:0]         hdr_hi_q;
    logic [7:0]         csum_q;
    logic [CNT_W-1:0]   cnt_q, total_q;

    logic               accept;
    logic               last_byte;
    logic               restart;
    logic [15:0]        n_words;
    logic [17:0]        n_bytes;

    assign accept    = in_valid && in_ready_q;
    assign n_words   = {hdr_hi_q, in_data};
    // Byte count kept at full 18-bit width so huge N cannot alias to a small size.
    assign n_bytes   = {n_words, 2'b00};
    assign last_byte = (cnt_q + CNT_W'(1)) == total_q;
    assign restart   = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = S_HDR_HI;
            S_HDR_HI: if (accept) state_d = S_HDR_LO;
            S_HDR_LO: begin
                if (accept) begin
                    if (n_bytes > 18'(MEM_BYTES)) state_d = ERR;
                    else if (n_words == 16'd0)    state_d = S_CSUM;
                    else                          state_d = S_DATA;
                end
            end
            S_DATA:   if (accept && last_byte) state_d = S_CSUM;
            S_CSUM:   if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
            DONE:     if (start) state_d = S_HDR_HI;
            ERR:      if (start) state_d = S_HDR_HI;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_ready(state_d);
            cpu_hold_q <= state_hold(state_d);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
            wr_en_q    <= 1'b0;

            if (restart) begin
                cnt_q  <= '0;
                csum_q <= '0;
            end

            case (state_q)
                S_HDR_HI: if (accept) hdr_hi_q <= in_data;
                S_HDR_LO: if (accept) total_q <= n_bytes[CNT_W-1:0];
                S_DATA: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q[ADDR_W-1:0];
                        wr_data_q <= in_data;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        csum_q    <= csum_q ^ in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader: frame-level reference model predicts
// memory writes and final status; a monitor checks every write strobe.
module tb_ins_mem_loader;

    typedef logic [7:0] u8;
    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       Reset, start, in_valid, in_ready;
    logic [7:0] in_data, wr_data;
    logic [6:0] wr_addr;
    logic       wr_en, cpu_hold, done, err;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cnt     = 0;
    int mon_seen    = 0;
    wr_t exp_q[$];

    ins_mem_loader #(.MEM_BYTES(128), .ADDR_W(7)) dut (
        .clk(clk), .Reset(Reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: a write strobe must appear exactly one cycle after each payload accept.
    always @(negedge clk) begin
        logic exp_wr;
        wr_t  e;
        exp_wr   = (acc_cnt != mon_seen);
        mon_seen = acc_cnt;
        chk("wr_en_timing", {31'd0, wr_en}, {31'd0, exp_wr});
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {25'd0, wr_addr}, {25'd0, e.a});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
            end
        end
    end

    task automatic check_status(input string tag, input logic ed, input logic ee,
                                input logic eh, input logic er);
        chk({tag, "_done"},  {31'd0, done},     {31'd0, ed});
        chk({tag, "_err"},   {31'd0, err},      {31'd0, ee});
        chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, eh});
        chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, er});
    endtask

    task automatic send_byte(input u8 b, input bit thr, input bit pulse, output bit ok);
        bit first;
        first = 1'b1;
        ok    = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            in_data  = b;
            in_valid = thr ? ($urandom_range(0, 2) == 0) : 1'b1;
            start    = pulse && first;
            first    = 1'b0;
            if (in_valid && in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_status("after_start", 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Reference model: frame = N (BE16), 4N payload bytes, XOR checksum.
    task automatic run_frame(input u8 fr[$], input bit thr, input int start_idx);
        int  n, nb, consumed;
        bit  ovf, good, ok;
        u8   cs;
        n   = {fr[0], fr[1]};
        nb  = 4 * n;
        ovf = nb > 128;
        cs  = 8'h00;
        consumed = ovf ? 2 : 2 + nb + 1;
        if (!ovf) for (int i = 0; i < nb; i++) cs ^= fr[2 + i];
        good = !ovf && (fr[2 + nb] == cs);

        pulse_start();
        for (int k = 0; k < consumed; k++) begin
            send_byte(fr[k], thr, k == start_idx, ok);
            if (!ok) return;
            if (k >= 2 && k < 2 + nb) begin
                exp_q.push_back('{a: 7'(k - 2), d: fr[k]});
                acc_cnt++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        check_status("end", good, !good, !good, 1'b0);
        // Further bytes must be refused with no side effects.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = u8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("quiet_ready", {31'd0, in_ready}, 32'd0);
        chk("pending_writes", exp_q.size(), 32'd0);
    endtask

    function automatic void make_frame(input int n, input bit good_cs, output u8 fr[$]);
        u8 cs;
        fr = {};
        fr.push_back(u8'(n >> 8));
        fr.push_back(u8'(n));
        cs = 8'h00;
        if (4 * n <= 128) begin
            for (int i = 0; i < 4 * n; i++) begin
                fr.push_back(u8'($urandom));
                cs ^= fr[fr.size() - 1];
            end
            fr.push_back(good_cs ? cs : (cs ^ u8'($urandom_range(1, 255))));
        end
    endfunction

    initial begin
        u8  fr[$];
        bit ok;
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        u8  fr[$];
        bit ok;
        Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_wr_addr", {25'd0, wr_addr}, 32'd0);
        chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        run_frame('{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h89}, 1'b0, -1);
        run_frame('{8'h00, 8'h00, 8'h00}, 1'b0, -1);
        run_frame('{8'h00, 8'h00, 8'h01}, 1'b0, -1);
        run_frame('{8'h00, 8'h21}, 1'b0, -1);
        run_frame('{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h89}, 1'b1, -1);

        // Reset in the middle of the payload.
        pulse_start();
        fr = '{8'h00, 8'h02, 8'h11, 8'h22};
        for (int k = 0; k < 4; k++) begin
            send_byte(fr[k], 1'b0, 1'b0, ok);
            if (k >= 2 && ok) begin
                exp_q.push_back('{a: 7'(k - 2), d: fr[k]});
                acc_cnt++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        Reset    = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check_status("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset_wr_en", {31'd0, wr_en}, 32'd0);
        run_frame('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 1'b0, -1);

        // start pulsed while in S_DATA has no effect.
        run_frame('{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h89}, 1'b0, 4);

        // Restart out of ERR with a two-word frame.
        run_frame('{8'h00, 8'h21}, 1'b0, -1);
        run_frame('{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'h10, 8'h20, 8'h30, 8'h40, 8'h74}, 1'b0, -1);

        // Size boundaries: full memory, one over, and counts whose 4N wraps 16 bits.
        make_frame(32, 1'b1, fr);
        run_frame(fr, 1'b0, -1);
        make_frame(33, 1'b1, fr);
        run_frame(fr, 1'b0, -1);
        run_frame('{8'h40, 8'h00}, 1'b0, -1);
        run_frame('{8'hFF, 8'hFF}, 1'b0, -1);

        for (int t = 0; t < 20; t++) begin
            make_frame($urandom_range(0, 34), $urandom_range(0, 3) != 0, fr);
            run_frame(fr, $urandom_range(0, 1) == 1, -1);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
